// File: rtl/data_cache.sv
// data_cache: 8-line x 4-byte direct-mapped, write-back, write-allocate data cache
// sitting between a byte-wide CPU port and a byte-wide memory port.
//
// Ports
//   clock          system clock, all state on rising edge
//   reset          synchronous, active-high
//   read, write    CPU request (exactly one high = valid access)
//   address        CPU byte address: tag=[7:5], index=[4:2], offset=[1:0]
//   writedata      CPU write byte
//   readdata       CPU read byte (0 unless read hit)
//   busywait       CPU stall
//   mem_read       memory read request
//   mem_write      memory write request
//   mem_address    memory byte address
//   mem_writedata  memory write byte
//   mem_readdata   memory read byte
//   mem_busywait   memory stall
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serve hits; on a miss latch the address and start a refill
// WRITEBACK | copy the dirty victim line to memory, one byte per beat
// FETCH     | read the requested line from memory, one byte per beat
// UPDATE    | mark the refilled line valid/clean with its new tag
module data_cache (
   input  logic       clock,
   input  logic       reset,
   input  logic       read,
   input  logic       write,
   input  logic [7:0] address,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic       busywait,
   output logic       mem_read,
   output logic       mem_write,
   output logic [7:0] mem_address,
   output logic [7:0] mem_writedata,
   input  logic [7:0] mem_readdata,
   input  logic       mem_busywait
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   state_t     state;
   state_t     state_next;

   logic [7:0] valid;
   logic [7:0] dirty;
   logic [2:0] tag_array  [8];
   logic [7:0] data_array [32];

   logic [7:0] addr_lat;
   logic [1:0] cnt;
   logic       seen_busy;

   logic [2:0] cpu_tag;
   logic [2:0] cpu_index;
   logic [1:0] cpu_offset;
   logic [2:0] lat_index;
   logic       hit;
   logic       valid_access;
   logic       read_hit;
   logic       write_hit;
   logic       mem_req;
   logic       beat_done;
   logic       last_beat;

   assign cpu_tag      = address[7:5];
   assign cpu_index    = address[4:2];
   assign cpu_offset   = address[1:0];
   assign lat_index    = addr_lat[4:2];

   assign hit          = valid[cpu_index] && (tag_array[cpu_index] == cpu_tag);
   assign valid_access = read ^ write;
   assign read_hit     = (state == IDLE) && read && !write && hit;
   assign write_hit    = (state == IDLE) && write && !read && hit;

   // A beat completes once memory has been seen busy and then drops busywait.
   assign mem_req      = mem_read | mem_write;
   assign beat_done    = mem_req && seen_busy && !mem_busywait;
   assign last_beat    = beat_done && (cnt == 2'd3);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busywait   = 1'b1;
      readdata   = 8'h00;
      case (state)
         IDLE: begin
            busywait = valid_access && !hit;
            if (read_hit) readdata = data_array[{cpu_index, cpu_offset}];
            if (valid_access && !hit)
               state_next = (valid[cpu_index] && dirty[cpu_index]) ? WRITEBACK : FETCH;
         end
         WRITEBACK: if (last_beat) state_next = FETCH;
         FETCH:     if (last_beat) state_next = UPDATE;
         UPDATE:    state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid         <= 8'h00;
         dirty         <= 8'h00;
         cnt           <= 2'd0;
         seen_busy     <= 1'b0;
         addr_lat      <= 8'h00;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= 8'h00;
         mem_writedata <= 8'h00;
      end else begin
         if (state_next != state) cnt <= 2'd0;
         else if (beat_done)      cnt <= cnt + 2'd1;

         if ((state == IDLE) && (state_next != IDLE)) addr_lat <= address;

         if (write_hit) dirty[cpu_index] <= 1'b1;

         if (state == UPDATE) begin
            valid[lat_index] <= 1'b1;
            dirty[lat_index] <= 1'b0;
         end

         case (state)
            WRITEBACK, FETCH: begin
               // Request low here is the mandatory gap cycle (or state entry);
               // raise the next beat with address/data registered and stable.
               if (!mem_req) begin
                  mem_write     <= (state == WRITEBACK);
                  mem_read      <= (state == FETCH);
                  mem_address   <= {((state == WRITEBACK) ? tag_array[lat_index] : addr_lat[7:5]),
                                    lat_index, cnt};
                  mem_writedata <= (state == WRITEBACK) ? data_array[{lat_index, cnt}] : 8'h00;
                  seen_busy     <= 1'b0;
               end else if (!seen_busy) begin
                  if (mem_busywait) seen_busy <= 1'b1;
               end else if (!mem_busywait) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  seen_busy <= 1'b0;
               end
            end
            default: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               seen_busy <= 1'b0;
            end
         endcase
      end
   end

   // Tag and data arrays are not cleared; valid bits hide stale contents.
   always_ff @(posedge clock) begin
      if (!reset && (state == UPDATE)) tag_array[lat_index] <= addr_lat[7:5];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         if (write_hit)
            data_array[{cpu_index, cpu_offset}] <= writedata;
         if ((state == FETCH) && beat_done)
            data_array[{lat_index, cnt}] <= mem_readdata;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed bench for data_cache with a behavioural byte memory
// (two-cycle access latency) and a bus monitor that logs every request beat.
module tb_data_cache;

   logic       clock = 1'b0;
   logic       reset;
   logic       read;
   logic       write;
   logic [7:0] address;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic       busywait;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] mem_address;
   logic [7:0] mem_writedata;
   logic [7:0] mem_readdata;
   logic       mem_busywait;

   always #5 clock = ~clock;

   data_cache dut (
      .clock         (clock),
      .reset         (reset),
      .read          (read),
      .write         (write),
      .address       (address),
      .writedata     (writedata),
      .readdata      (readdata),
      .busywait      (busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   // Memory model: busywait rises with a request and falls two edges later.
   logic [7:0] mem [256];
   logic       mem_init;
   logic       acc_done;
   logic [1:0] lat;

   assign mem_busywait = (mem_read || mem_write) && !acc_done;

   function automatic logic [7:0] init_byte(input logic [7:0] a);
      case (a)
         8'h00:   return 8'h11;
         8'h01:   return 8'h22;
         8'h02:   return 8'h33;
         8'h03:   return 8'h44;
         default: return a + 8'h80;
      endcase
   endfunction

   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_byte(8'(i));
         acc_done     <= 1'b0;
         lat          <= 2'd0;
         mem_readdata <= 8'h00;
      end else if (!(mem_read || mem_write)) begin
         acc_done <= 1'b0;
         lat      <= 2'd0;
      end else if (!acc_done) begin
         if (lat == 2'd1) begin
            acc_done <= 1'b1;
            if (mem_write) mem[mem_address] <= mem_writedata;
            else           mem_readdata     <= mem[mem_address];
         end else begin
            lat <= lat + 2'd1;
         end
      end
   end

   // Bus monitor: one log entry per rising request edge.
   logic       prev_req = 1'b0;
   int         overlap_cnt = 0;
   logic [7:0] log_addr [$];
   logic       log_wr   [$];
   logic [7:0] log_data [$];

   always @(negedge clock) begin
      if (mem_read && mem_write) overlap_cnt++;
      if ((mem_read || mem_write) && !prev_req) begin
         log_addr.push_back(mem_address);
         log_wr.push_back(mem_write);
         log_data.push_back(mem_write ? mem_writedata : 8'h00);
      end
      prev_req = mem_read || mem_write;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_wr.delete();
      log_data.delete();
   endtask

   // Compares one logged beat as {wr, addr, data}; a missing beat reads as all ones.
   task automatic check_beat(input string tag, input int idx, input logic wr,
                             input logic [7:0] a, input logic [7:0] d);
      logic [17:0] got;
      if (idx < log_addr.size()) got = {1'b0, log_wr[idx], log_addr[idx], log_data[idx]};
      else                       got = '1;
      check($sformatf("%s_beat%0d", tag, idx), 32'(got), 32'({1'b0, wr, a, d}));
   endtask

   task automatic wait_ready(input string tag);
      int cyc = 0;
      while (busywait !== 1'b0 && cyc < 300) begin
         @(negedge clock);
         cyc++;
      end
      check({tag, "_ready"}, 32'(busywait), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      read      = 1'b0;
      write     = 1'b0;
      address   = 8'h00;
      writedata = 8'h00;
      mem_init  = 1'b1;
      repeat (3) @(negedge clock);
      reset    = 1'b0;
      mem_init = 1'b0;
      #1;
      check("rst_busywait", 32'(busywait), 32'd0);
      check("rst_readdata", 32'(readdata), 32'h00);
      check("rst_mem_req", 32'({mem_read, mem_write}), 32'd0);
      check("rst_mem_addr", 32'(mem_address), 32'h00);
      check("rst_mem_wdata", 32'(mem_writedata), 32'h00);

      // Cold read miss at 0x00
      @(negedge clock);
      clear_log();
      read = 1'b1; address = 8'h00;
      #1 check("rd00_miss_busy", 32'(busywait), 32'd1);
      wait_ready("rd00");
      check("rd00_data", 32'(readdata), 32'h11);
      check("rd00_nbeats", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) check_beat("rd00", i, 1'b0, 8'(i), 8'h00);
      address = 8'h03;
      #1;
      check("rd03_hit_busy", 32'(busywait), 32'd0);
      check("rd03_data", 32'(readdata), 32'h44);
      @(negedge clock); #1;
      check("rd03_no_traffic", 32'(log_addr.size()), 32'd4);

      // Write miss on clean line 1, allocate then write
      @(negedge clock);
      clear_log();
      read = 1'b0; write = 1'b1; address = 8'h05; writedata = 8'hAB;
      #1 check("wr05_miss_busy", 32'(busywait), 32'd1);
      wait_ready("wr05");
      check("wr05_nbeats", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) check_beat("wr05", i, 1'b0, 8'(4 + i), 8'h00);
      @(negedge clock);
      write = 1'b0; read = 1'b1; address = 8'h05;
      #1;
      check("rd05_busy", 32'(busywait), 32'd0);
      check("rd05_data", 32'(readdata), 32'hAB);
      @(negedge clock); #1;
      check("rd05_no_traffic", 32'(log_addr.size()), 32'd4);

      // Conflict miss on dirty line 1: write-back then fetch
      @(negedge clock);
      clear_log();
      address = 8'h25;
      #1 check("rd25_miss_busy", 32'(busywait), 32'd1);
      wait_ready("rd25");
      check("rd25_data", 32'(readdata), 32'hA5);
      check("rd25_nbeats", 32'(log_addr.size()), 32'd8);
      check_beat("rd25", 0, 1'b1, 8'h04, 8'h84);
      check_beat("rd25", 1, 1'b1, 8'h05, 8'hAB);
      check_beat("rd25", 2, 1'b1, 8'h06, 8'h86);
      check_beat("rd25", 3, 1'b1, 8'h07, 8'h87);
      for (int i = 0; i < 4; i++) check_beat("rd25", 4 + i, 1'b0, 8'(8'h24 + i), 8'h00);
      check("mem05_written", 32'(mem[8'h05]), 32'hAB);
      check("no_overlap", 32'(overlap_cnt), 32'd0);

      // read and write together: ignored
      @(negedge clock);
      clear_log();
      read = 1'b1; write = 1'b1; address = 8'h00; writedata = 8'hEE;
      #1;
      check("rw_busy", 32'(busywait), 32'd0);
      check("rw_readdata", 32'(readdata), 32'h00);
      repeat (2) @(negedge clock);
      #1 check("rw_no_traffic", 32'(log_addr.size()), 32'd0);
      write = 1'b0;
      #1;
      check("rw_line0_b0", 32'(readdata), 32'h11);
      check("rw_line0_busy", 32'(busywait), 32'd0);
      address = 8'h02;
      #1 check("rw_line0_b2", 32'(readdata), 32'h33);

      // Reset during beat 2 of a fetch
      @(negedge clock);
      clear_log();
      address = 8'h45;
      begin
         int cyc = 0;
         while (log_addr.size() < 3 && cyc < 300) begin
            @(negedge clock); #1;
            cyc++;
         end
      end
      check("rst_mid_beat2_reached", 32'(log_addr.size()), 32'd3);
      reset = 1'b1;
      @(negedge clock); #1;
      check("rst_mid_req_low", 32'({mem_read, mem_write}), 32'd0);
      reset = 1'b0; read = 1'b0;
      #1 check("rst_mid_idle_busy", 32'(busywait), 32'd0);
      @(negedge clock);
      clear_log();
      read = 1'b1; address = 8'h45;
      #1 check("rd45_miss_again", 32'(busywait), 32'd1);
      wait_ready("rd45");
      check("rd45_data", 32'(readdata), 32'hC5);
      check("rd45_nbeats", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) check_beat("rd45", i, 1'b0, 8'(8'h44 + i), 8'h00);
      @(negedge clock);
      address = 8'h00;
      #1 check("rd00_after_rst_miss", 32'(busywait), 32'd1);
      wait_ready("rd00b");
      check("rd00b_data", 32'(readdata), 32'h11);
      check("no_overlap_end", 32'(overlap_cnt), 32'd0);

      read = 1'b0;
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 lines x 4 bytes, direct-mapped, write-back, write-allocate.
REQ-002 The block SHALL have these ports, clock and reset first:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- read  in  1  CPU read request
- write  in  1  CPU write request
- address  in  8  CPU byte address: tag=[7:5], index=[4:2], offset=[1:0]
- writedata  in  8  CPU write byte
- readdata  out  8  CPU read byte
- busywait  out  1  CPU stall
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_address  out  8  memory byte address
- mem_writedata  out  8  memory write byte
- mem_readdata  in  8  memory read byte
- mem_busywait  in  1  memory stall, rises combinationally with mem_read/mem_write and falls when the access completes

Function
REQ-003 Hit SHALL mean valid[index] and tag[index]==address[7:5]; valid CPU access SHALL mean exactly one of read/write is high.
REQ-004 read==write==1 SHALL be ignored: no state change, busywait=0.
REQ-005 Read hit in IDLE SHALL give readdata=data[index][offset] combinationally, busywait=0, zero stall cycles.
REQ-006 Write hit in IDLE SHALL write the byte and set dirty[index] at the next rising edge, busywait=0.
REQ-007 readdata SHALL be 0 when there is no read hit.
REQ-008 busywait SHALL be high when a valid access misses in IDLE, and in every non-IDLE state.
REQ-009 The FSM SHALL have states IDLE, WRITEBACK, FETCH and UPDATE.
REQ-010 On a miss in IDLE, the block SHALL latch address and go to WRITEBACK if valid&dirty, otherwise to FETCH, with beat counter=0.
REQ-011 Memory beat protocol: assert exactly one request with stable address/data, hold it until mem_busywait is sampled high and then low at rising edges, then drop the request for exactly one cycle before the next beat (memory detects accesses on request edges).
REQ-012 WRITEBACK SHALL drive mem_write=1, mem_address={old_tag,index,cnt}, mem_writedata=data[index][cnt] for cnt=0..3, then go to FETCH.
REQ-013 FETCH SHALL drive mem_read=1, mem_address={latched_tag,index,cnt} for cnt=0..3, and capture mem_readdata into data[index][cnt] on each completed beat.
REQ-014 After beat 3 the block SHALL go to UPDATE, then set valid=1, tag=latched_tag and dirty=0 in one cycle, then go to IDLE.
REQ-015 After UPDATE the CPU access SHALL be served as a hit in IDLE, and busywait SHALL fall in that cycle.
REQ-016 The CPU SHALL hold read/write/address/writedata stable while busywait=1; the cache SHALL use only the latched address for memory traffic.
REQ-017 mem_read and mem_write SHALL never be high together, and both SHALL be 0 in IDLE and UPDATE.
REQ-018 The beat counter SHALL be 2 bits and reset to 0 on every state entry; it SHALL never wrap within a state.

Reset
REQ-019 With reset high at a rising edge, the block SHALL clear all valid and dirty bits, set state=IDLE and cnt=0, and set mem_read=mem_write=0, mem_address=0 and mem_writedata=0.
REQ-020 Reset mid-WRITEBACK/FETCH SHALL abort the miss (dirty data discarded) and drop memory requests at that edge.
REQ-021 After reset with read=write=0, outputs SHALL be busywait=0, readdata=0.
REQ-022 Data array contents need not be cleared; they SHALL be unobservable while invalid.

Verification
REQ-023 Reset, then read 0x00 with memory[0x00..0x03]=11,22,33,44 -> four mem_read beats at 0x00..0x03, then UPDATE, busywait falls, readdata=0x11; a following read of 0x03 hits with busywait=0 and readdata=0x44.
REQ-024 Write 0xAB to 0x05 (clean miss) -> fetch 0x04..0x07, then write; a following read of 0x05 returns 0xAB with no memory traffic; dirty[1]=1.
REQ-025 Read 0x25 (same index 1, tag 1, line dirty) -> write-back beats at 0x04..0x07 with 0xAB at 0x05, then fetch 0x24..0x27; memory[0x05]=0xAB.
REQ-026 Gap check: every pair of consecutive beats has >=1 cycle with mem_read=mem_write=0; mem_read&mem_write is never observed.
REQ-027 Reset asserted during beat 2 of FETCH -> requests low next cycle; a read of the same address then misses again.
REQ-028 read=write=1 at 0x00 after line 0 is valid -> busywait=0, no memory request, line 0 contents unchanged.
